dlx_decode_stage: RTL

//  Registered, handshaked DLX decode stage; successor to the combinational control decoder.

---
 rtl/dlx_decode_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dlx_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dlx_decode_stage                                                 |
// | Brief   : Registered valid/ready DLX decoder with load-use interlock.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dlx_decode_stage #(
    parameter int unsigned LOAD_DELAY = 1,
    parameter int unsigned LINK_REG   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [5:0]  out_func,
    output logic [16:0] out_ctrl,
    output logic        out_illegal
);

    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_fparith = 6'h01;
    localparam logic [5:0] c_op_j       = 6'h02;
    localparam logic [5:0] c_op_jal     = 6'h03;
    localparam logic [5:0] c_op_beqz    = 6'h04;
    localparam logic [5:0] c_op_bnez    = 6'h05;
    localparam logic [5:0] c_op_addi    = 6'h08;
    localparam logic [5:0] c_op_addui   = 6'h09;
    localparam logic [5:0] c_op_subi    = 6'h0A;
    localparam logic [5:0] c_op_subui   = 6'h0B;
    localparam logic [5:0] c_op_andi    = 6'h0C;
    localparam logic [5:0] c_op_ori     = 6'h0D;
    localparam logic [5:0] c_op_xori    = 6'h0E;
    localparam logic [5:0] c_op_lhi     = 6'h0F;
    localparam logic [5:0] c_op_jr      = 6'h12;
    localparam logic [5:0] c_op_jalr    = 6'h13;
    localparam logic [5:0] c_op_slli    = 6'h14;
    localparam logic [5:0] c_op_srli    = 6'h16;
    localparam logic [5:0] c_op_srai    = 6'h17;
    localparam logic [5:0] c_op_seqi    = 6'h18;
    localparam logic [5:0] c_op_snei    = 6'h19;
    localparam logic [5:0] c_op_slti    = 6'h1A;
    localparam logic [5:0] c_op_sgti    = 6'h1B;
    localparam logic [5:0] c_op_slei    = 6'h1C;
    localparam logic [5:0] c_op_sgei    = 6'h1D;
    localparam logic [5:0] c_op_lb      = 6'h20;
    localparam logic [5:0] c_op_lh      = 6'h21;
    localparam logic [5:0] c_op_lw      = 6'h23;
    localparam logic [5:0] c_op_lbu     = 6'h24;
    localparam logic [5:0] c_op_lhu     = 6'h25;
    localparam logic [5:0] c_op_sb      = 6'h28;
    localparam logic [5:0] c_op_sh      = 6'h29;
    localparam logic [5:0] c_op_sw      = 6'h2B;

    localparam bit         c_interlock_en  = (LOAD_DELAY != 0);
    // The hazard cycle itself yields the first bubble, so the counter covers the rest.
    localparam logic [1:0] c_bubble_reload = (LOAD_DELAY > 1) ? 2'(LOAD_DELAY - 1) : 2'd0;

    logic [5:0]  w_op;
    logic        w_is_r, w_is_load, w_is_store, w_is_alu_imm, w_is_link, w_is_jump;
    logic        w_legal, w_zext, w_writes;
    logic [4:0]  w_rs2, w_rd;
    logic [31:0] w_imm;
    logic [5:0]  w_imm_func, w_func;
    logic [16:0] w_ctrl;
    logic        w_uses_rs1, w_uses_rs2, w_hazard;

    logic        r_out_valid;
    logic [1:0]  r_bubble_cnt;
    logic [31:0] r_pc, r_imm;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic [5:0]  r_func;
    logic [16:0] r_ctrl;
    logic        r_illegal;

    assign w_op         = in_inst[31:26];
    assign w_is_r       = (w_op == c_op_special) || (w_op == c_op_fparith);
    assign w_is_load    = w_op inside {c_op_lb, c_op_lh, c_op_lw, c_op_lbu, c_op_lhu};
    assign w_is_store   = w_op inside {c_op_sb, c_op_sh, c_op_sw};
    assign w_is_alu_imm = w_op inside {[c_op_addi:c_op_lhi], c_op_slli, c_op_srli, c_op_srai,
                                       [c_op_seqi:c_op_sgei]};
    assign w_is_link    = (w_op == c_op_jal) || (w_op == c_op_jalr);
    assign w_is_jump    = w_op inside {c_op_j, c_op_jal, c_op_jr, c_op_jalr};
    assign w_legal      = w_is_r || w_is_load || w_is_store || w_is_alu_imm || w_is_jump ||
                          (w_op == c_op_beqz) || (w_op == c_op_bnez);
    assign w_zext       = w_op inside {c_op_addui, c_op_subui, c_op_andi, c_op_ori, c_op_xori};
    assign w_writes     = w_is_r || w_is_alu_imm || w_is_load || w_is_link;
    assign w_rs2        = (w_is_r || w_is_store) ? in_inst[20:16] : 5'd0;

    always_comb begin
        w_imm_func = 6'h00;
        case (w_op)
            c_op_addi:  w_imm_func = 6'h20;
            c_op_addui: w_imm_func = 6'h21;
            c_op_subi:  w_imm_func = 6'h22;
            c_op_subui: w_imm_func = 6'h23;
            c_op_andi:  w_imm_func = 6'h24;
            c_op_ori:   w_imm_func = 6'h25;
            c_op_xori:  w_imm_func = 6'h26;
            c_op_slli:  w_imm_func = 6'h04;
            c_op_srli:  w_imm_func = 6'h06;
            c_op_srai:  w_imm_func = 6'h07;
            c_op_seqi:  w_imm_func = 6'h28;
            c_op_snei:  w_imm_func = 6'h29;
            c_op_slti:  w_imm_func = 6'h2A;
            c_op_sgti:  w_imm_func = 6'h2B;
            c_op_slei:  w_imm_func = 6'h2C;
            c_op_sgei:  w_imm_func = 6'h2D;
            default:    w_imm_func = 6'h00;
        endcase
    end

    always_comb begin
        w_rd = 5'd0;
        if (w_legal) begin
            if (w_is_r)                        w_rd = in_inst[15:11];
            else if (w_is_alu_imm || w_is_load) w_rd = in_inst[20:16];
            else if (w_is_link)                w_rd = 5'(LINK_REG);
        end

        if (w_op == c_op_lhi)                         w_imm = {in_inst[15:0], 16'h0000};
        else if ((w_op == c_op_j) || (w_op == c_op_jal)) w_imm = {{6{in_inst[25]}}, in_inst[25:0]};
        else if (w_zext)                              w_imm = {16'h0000, in_inst[15:0]};
        else                                          w_imm = {{16{in_inst[15]}}, in_inst[15:0]};

        w_func = 6'h00;
        if (w_legal) begin
            if (w_is_r)                       w_func = in_inst[5:0];
            else if (w_is_load || w_is_store) w_func = 6'h20;
            else                              w_func = w_imm_func;
        end

        w_ctrl = 17'd0;
        if (w_legal) begin
            w_ctrl[0]  = w_is_store;
            w_ctrl[1]  = w_writes && (w_rd != 5'd0);
            w_ctrl[2]  = w_is_r;
            w_ctrl[3]  = (w_op == c_op_beqz);
            w_ctrl[4]  = (w_op == c_op_bnez);
            w_ctrl[5]  = w_is_jump;
            w_ctrl[6]  = (w_op == c_op_jr) || (w_op == c_op_jalr);
            w_ctrl[7]  = w_is_link;
            w_ctrl[8]  = !w_is_r;
            w_ctrl[9]  = !w_zext;
            w_ctrl[10] = !((w_op == c_op_lbu) || (w_op == c_op_lhu));
            w_ctrl[11] = w_is_load;
            w_ctrl[12] = (w_op == c_op_sb);
            w_ctrl[13] = (w_op == c_op_sh);
            w_ctrl[14] = (w_op == c_op_lb) || (w_op == c_op_lbu);
            w_ctrl[15] = (w_op == c_op_lh) || (w_op == c_op_lhu);
            w_ctrl[16] = (w_op == c_op_lhi);
        end
    end

    // Load-use: the held load's destination is a source of the incoming instruction.
    assign w_uses_rs1 = !((w_op == c_op_j) || (w_op == c_op_jal));
    assign w_uses_rs2 = w_is_r || w_is_store;
    assign w_hazard   = c_interlock_en && r_out_valid && r_ctrl[11] && (r_rd != 5'd0) && in_valid &&
                        ((w_uses_rs1 && (in_inst[25:21] == r_rd)) ||
                         (w_uses_rs2 && (in_inst[20:16] == r_rd)));

    assign in_ready = flush ||
                      ((!r_out_valid || out_ready) && (r_bubble_cnt == 2'd0) && !w_hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_bubble_cnt <= 2'd0;
            r_pc         <= 32'd0;
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
            r_imm        <= 32'd0;
            r_func       <= 6'd0;
            r_ctrl       <= 17'd0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_bubble_cnt <= 2'd0;
        end else if (r_bubble_cnt != 2'd0) begin
            r_bubble_cnt <= r_bubble_cnt - 2'd1;
        end else if (in_valid && in_ready) begin
            r_out_valid  <= 1'b1;
            r_pc         <= in_pc;
            r_rs1        <= in_inst[25:21];
            r_rs2        <= w_rs2;
            r_rd         <= w_rd;
            r_imm        <= w_imm;
            r_func       <= w_func;
            r_ctrl       <= w_ctrl;
            r_illegal    <= !w_legal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_hazard) begin
                r_bubble_cnt <= c_bubble_reload;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_pc;
    assign out_rs1     = r_rs1;
    assign out_rs2     = r_rs2;
    assign out_rd      = r_rd;
    assign out_imm     = r_imm;
    assign out_func    = r_func;
    assign out_ctrl    = r_ctrl;
    assign out_illegal = r_illegal;

endmodule
`default_nettype wire
